// File: rtl/hs_responder.sv
// hs_responder: responder end of a valid/ready request bus.
// Each accepted request is complemented, tagged with a rolling sequence
// number, held for LAT cycles, then queued in a small in-order response FIFO
// that absorbs backpressure on the response channel.
module hs_responder #(
  parameter int DATA_W = 3,
  parameter int LAT    = 2,   // 1..15
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int TAG_W  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int EW   = TAG_W + DATA_W;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [TAG_W-1:0]    seq_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DATA_W-1:0]   data_q;

  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic req_fire, push, pop;
  logic [EW-1:0] head;

  // Acceptance depends only on registered state (and the reset pin), never
  // on req_valid or rsp_ready, so there is no combinational loop through us.
  assign req_ready = !sys_rst && (state_q == IDLE) && (count_q < FULL);
  assign req_fire  = req_valid && req_ready;

  // The single in-flight request is pushed on the last WORK cycle; the space
  // check at acceptance guarantees the FIFO has room for it.
  assign push = (state_q == WORK) && (cnt_q == 4'd0);
  assign pop  = rsp_valid && rsp_ready;

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? head[DATA_W-1:0] : '0;
  assign rsp_tag   = rsp_valid ? head[EW-1:DATA_W] : '0;
  assign busy      = (state_q == WORK) || (count_q != '0);

  // Request FSM: latch transformed payload and tag, count out the latency.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            data_q  <= ~req_data;
            tag_q   <= seq_q;
            seq_q   <= seq_q + 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= WORK;
          end
        end
        WORK: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO next state: simultaneous push and pop advance both pointers and
  // leave the occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tag_q, data_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state; reset discards every queued response.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_hs_responder.sv
// Bench for hs_responder: a queue-based reference model tracks the in-flight
// request and pending responses; directed scenarios plus random traffic.
module tb_hs_responder;
  localparam int DW = 3, TW = 2, LAT = 2, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rv, rr;
  logic [DW-1:0] rdat;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;

  hs_responder #(.DATA_W(DW), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .sys_clk(clk), .sys_rst(rst), .req_valid(rv), .req_data(rdat),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rr), .busy(busy));

  // Latency-only instances for the extreme LAT values.
  logic a_v, a_rr, a_rdy, a_val, a_busy;
  logic [DW-1:0] a_d, a_rd;
  logic [TW-1:0] a_tag;
  hs_responder #(.DATA_W(DW), .LAT(1), .DEPTH(DEPTH), .TAG_W(TW)) dut_l1 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(a_v), .req_data(a_d),
    .req_ready(a_rdy), .rsp_valid(a_val), .rsp_data(a_rd),
    .rsp_tag(a_tag), .rsp_ready(a_rr), .busy(a_busy));

  logic b_v, b_rr, b_rdy, b_val, b_busy;
  logic [DW-1:0] b_d, b_rd;
  logic [TW-1:0] b_tag;
  hs_responder #(.DATA_W(DW), .LAT(15), .DEPTH(DEPTH), .TAG_W(TW)) dut_l15 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(b_v), .req_data(b_d),
    .req_ready(b_rdy), .rsp_valid(b_val), .rsp_data(b_rd),
    .rsp_tag(b_tag), .rsp_ready(b_rr), .busy(b_busy));

  int n_chk = 0, n_pass = 0;

  // Reference model: pending responses in order, plus at most one request
  // waiting out its latency.
  logic [TW+DW-1:0] q[$];
  logic [TW+DW-1:0] cur;
  bit inflight;
  int left, seq;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q.delete(); inflight = 0; left = 0; seq = 0;
  endtask

  task automatic check_outputs();
    logic [TW+DW-1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("req_ready", 8'(req_ready), 8'(!rst && !inflight && q.size() < DEPTH));
    chk("rsp_valid", 8'(rsp_valid), 8'(q.size() != 0));
    chk("rsp_data",  8'(rsp_data),  8'(h[DW-1:0]));
    chk("rsp_tag",   8'(rsp_tag),   8'(h[TW+DW-1:DW]));
    chk("busy",      8'(busy),      8'(inflight || q.size() != 0));
  endtask

  // One clock of traffic on the main DUT; returns whether the request fired.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rrdy, output bit fired);
    bit popped;
    @(negedge clk);
    rv = v; rdat = d; rr = rrdy;
    #1;
    check_outputs();
    fired  = v && !inflight && q.size() < DEPTH;
    popped = rrdy && q.size() != 0;
    @(posedge clk);
    if (popped) void'(q.pop_front());
    if (inflight) begin
      left--;
      if (left == 0) begin q.push_back(cur); inflight = 0; end
    end
    if (fired) begin
      inflight = 1; left = LAT;
      cur = {TW'(seq), ~d};
      seq = (seq + 1) % (1 << TW);
    end
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic rrdy, input int budget, output bit fired);
    fired = 0;
    for (int i = 0; i < budget && !fired; i++) step(1'b1, d, rrdy, fired);
  endtask

  task automatic idle(input int n, input logic rrdy);
    bit f;
    for (int i = 0; i < n; i++) step(1'b0, '0, rrdy, f);
  endtask

  task automatic do_reset(input int n, input logic v);
    @(negedge clk);
    rst = 1'b1; rv = v; rdat = 3'b111;
    model_clear();
    for (int i = 0; i < n; i++) begin
      #1 check_outputs();
      @(negedge clk);
    end
    rst = 1'b0; rv = 1'b0;
  endtask

  // Edge-count from acceptance to rsp_valid on one of the latency instances.
  task automatic measure(input bit sel15, input int lat);
    int k;
    bit seen;
    @(negedge clk);
    if (sel15) begin b_v = 1; b_d = 3'b110; end else begin a_v = 1; a_d = 3'b110; end
    #1 chk("lat_ready", 8'(sel15 ? b_rdy : a_rdy), 8'd1);
    @(posedge clk);
    #1;
    if (sel15) b_v = 0; else a_v = 0;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(posedge clk); k++;
      #1 seen = sel15 ? b_val : a_val;
    end
    chk(sel15 ? "lat15" : "lat1", 8'(k), 8'(lat));
    chk("lat_data", 8'(sel15 ? b_rd : a_rd), 8'b001);
    chk("lat_tag",  8'(sel15 ? b_tag : a_tag), 8'd0);
    @(negedge clk);
    if (sel15) b_rr = 1; else a_rr = 1;
    @(negedge clk);
    if (sel15) b_rr = 0; else a_rr = 0;
    #1 chk("lat_drained", 8'(sel15 ? b_busy : a_busy), 8'd0);
  endtask

  initial begin
    bit f;
    rv = 0; rr = 0; rdat = '0;
    a_v = 0; a_d = '0; a_rr = 0; b_v = 0; b_d = '0; b_rr = 0;
    model_clear();

    // Reset with a request offered: nothing accepted, nothing emitted.
    do_reset(3, 1'b1);
    idle(3, 1'b1);

    // Single request, directed value.
    step(1'b1, 3'b101, 1'b0, f);
    chk("single_fired", 8'(f), 8'd1);
    idle(3, 1'b0);
    chk("single_data", 8'(rsp_data), 8'b010);
    chk("single_tag",  8'(rsp_tag),  8'd0);
    idle(2, 1'b1);
    chk("single_busy", 8'(busy), 8'd0);

    // Backpressure: four fit, the fifth waits until drained.
    model_clear();
    do_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      offer(DW'(i), 1'b0, 8, f);
      chk("bp_accept", 8'(f), 8'd1);
    end
    offer(3'd4, 1'b0, 10, f);
    chk("bp_fifth_blocked", 8'(f), 8'd0);
    chk("bp_head_data", 8'(rsp_data), 8'b111);
    chk("bp_head_tag",  8'(rsp_tag),  8'd0);
    offer(3'd4, 1'b1, 10, f);
    chk("bp_fifth_accept", 8'(f), 8'd1);
    idle(10, 1'b1);

    // Push and pop on the same edge with three entries queued.
    for (int i = 0; i < 3; i++) offer(DW'(i + 1), 1'b0, 8, f);
    idle(LAT + 1, 1'b0);
    offer(3'd6, 1'b0, 4, f);
    while (inflight && left != 1) idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(8, 1'b1);

    // Reset while working with two queued responses.
    offer(3'd1, 1'b0, 8, f);
    offer(3'd2, 1'b0, 8, f);
    idle(LAT + 1, 1'b0);
    offer(3'd3, 1'b0, 4, f);
    do_reset(2, 1'b0);
    offer(3'd5, 1'b1, 4, f);
    idle(LAT + 1, 1'b0);
    chk("rst_new_tag",  8'(rsp_tag),  8'd0);
    chk("rst_new_data", 8'(rsp_data), 8'b010);
    idle(2, 1'b1);

    // Random traffic; payload held while waiting.
    begin
      logic pv;
      logic [DW-1:0] pd;
      pv = 0; pd = '0;
      for (int i = 0; i < 400; i++) begin
        if (!pv) begin
          pv = ($urandom_range(0, 2) != 0);
          pd = DW'($urandom);
        end
        step(pv, pd, ($urandom_range(0, 3) != 0), f);
        if (f) pv = 0;
      end
    end
    idle(12, 1'b1);

    measure(1'b0, 1);
    measure(1'b1, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
